// File: rtl/ram_sync_clr.sv
// rtl/ram_sync_clr.sv - single-port synchronous RAM with byte enables and a clear sweep engine
//
// Purpose:
//   DEPTH = 2**ADDR_W words of DATA_W bits. Requests arrive on a valid/ready
//   port. Reads answer exactly one cycle after accept. A clear engine writes
//   CLR_VALUE to every address, either after reset (CLR_ON_RST=1) or when
//   clr_start is seen in IDLE.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   req_valid  in   request present
//   req_ready  out  request accepted this cycle (state == IDLE)
//   req_we     in   1 = write, 0 = read
//   req_addr   in   word address
//   req_wdata  in   write data
//   req_be     in   byte enables for writes
//   rsp_valid  out  one-cycle pulse per accepted read
//   rsp_rdata  out  read data, held between responses
//   clr_start  in   request a clear sweep (ignored while sweeping)
//   busy       out  clear sweep in progress
//   clr_done   out  one-cycle pulse on the first IDLE cycle after a sweep

module ram_sync_clr #(
   parameter int                DATA_W     = 8,
   parameter int                ADDR_W     = 2,
   parameter int                CLR_ON_RST = 1,
   parameter logic [DATA_W-1:0] CLR_VALUE  = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   input  logic [DATA_W/8-1:0]   req_be,
   output logic                  rsp_valid,
   output logic [DATA_W-1:0]     rsp_rdata,
   input  logic                  clr_start,
   output logic                  busy,
   output logic                  clr_done
);

   localparam int DEPTH = 2**ADDR_W;
   localparam int NB    = DATA_W/8;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   localparam state_t RST_STATE = (CLR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;

   state_t              r_state;
   state_t              w_next;
   logic [DATA_W-1:0]   r_mem [DEPTH];
   logic [ADDR_W-1:0]   r_clr_ptr;
   logic                r_clr_done;
   logic                r_rsp_valid;
   logic [DATA_W-1:0]   r_rsp_rdata;
   logic                w_accept;
   logic                w_ptr_last;

   // Accept depends only on registered state, so req_ready never sees req_valid.
   assign w_accept   = req_valid && (r_state == ST_IDLE);
   assign w_ptr_last = (r_clr_ptr == ADDR_W'(DEPTH-1));

   assign req_ready = (r_state == ST_IDLE);
   assign busy      = (r_state == ST_CLEAR);
   assign clr_done  = r_clr_done;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= RST_STATE;
      end else begin
         r_state <= w_next;
      end
   end

   // clr_start is only looked at in IDLE, so a mid-sweep pulse cannot restart it.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (clr_start)  w_next = ST_CLEAR;
         ST_CLEAR: if (w_ptr_last) w_next = ST_IDLE;
         default:  w_next = RST_STATE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_clr_ptr   <= '0;
         r_clr_done  <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         r_clr_done  <= (r_state == ST_CLEAR) && w_ptr_last;
         r_rsp_valid <= w_accept && !req_we;
         // Reads sample the array before this edge's write lands, so a read
         // accepted together with clr_start returns pre-clear data.
         if (w_accept && !req_we) begin
            r_rsp_rdata <= r_mem[req_addr];
         end
         if (r_state == ST_CLEAR) begin
            r_clr_ptr <= w_ptr_last ? '0 : r_clr_ptr + 1'b1;
         end else begin
            r_clr_ptr <= '0;
         end
      end
   end

   // Storage has no reset; only the sweep initialises it.
   always_ff @(posedge clk) begin
      if (r_state == ST_CLEAR) begin
         r_mem[r_clr_ptr] <= CLR_VALUE;
      end else if (w_accept && req_we) begin
         for (int b = 0; b < NB; b++) begin
            if (req_be[b]) begin
               r_mem[req_addr][8*b +: 8] <= req_wdata[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_ram_sync_clr.sv
// tb/tb_ram_sync_clr.sv - scoreboard testbench for ram_sync_clr

module tb_ram_sync_clr;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_addr = '0;
   logic [15:0] req_wdata = '0;
   logic [1:0]  req_be = '0;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic        clr_start = 1'b0;
   logic        busy;
   logic        clr_done;

   typedef struct {
      logic [15:0] d;
      int          c;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_pass = 0;
   int   n_total = 0;
   int   n;

   ram_sync_clr #(
      .DATA_W(16), .ADDR_W(3), .CLR_ON_RST(1), .CLR_VALUE(16'h0000)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .clr_start(clr_start), .busy(busy), .clr_done(clr_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Monitor: every response must match the oldest queued expectation in both
   // data and arrival cycle (accept edge + 1).
   always @(negedge clk) begin
      exp_t e;
      if (rsp_valid === 1'b1) begin
         check("rsp_expected", (q.size() != 0), 1);
         if (q.size() != 0) begin
            e = q.pop_front();
            check("rsp_data", rsp_rdata, e.d);
            check("rsp_cycle", cyc, e.c);
         end
      end
   end

   task automatic step(input int k);
      repeat (k) begin @(posedge clk); #1; end
   endtask

   task automatic req(input logic we, input logic [2:0] a, input logic [15:0] wd,
                      input logic [1:0] be, input logic [15:0] exp);
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_be = be;
      check("req_ready", req_ready, 1);
      if (!we) q.push_back('{exp, cyc + 1});
      @(posedge clk); #1;
   endtask

   task automatic req_off();
      req_valid = 1'b0; req_we = 1'b0; req_be = '0;
   endtask

   task automatic count_busy(output int cnt);
      cnt = 0;
      while (busy === 1'b1 && cnt < 20) begin @(posedge clk); #1; cnt++; end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      // 1. reset sweep
      #1 rst = 1'b1;
      step(2);
      check("rst_busy", busy, 1);
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_rdata", rsp_rdata, 16'h0000);
      check("rst_clr_done", clr_done, 0);
      rst = 1'b0;
      count_busy(n);
      check("sweep_len", n, 8);
      check("clr_done_pulse", clr_done, 1);
      check("ready_after_sweep", req_ready, 1);
      step(1);
      check("clr_done_drop", clr_done, 0);
      for (int k = 0; k < 8; k++) req(1'b0, 3'(k), 16'h0, 2'b00, 16'h0000);
      req_off();
      step(2);

      // 2. write then read
      req(1'b1, 3'd3, 16'hA55A, 2'b11, 16'h0);
      req(1'b0, 3'd3, 16'h0, 2'b00, 16'hA55A);
      req_off();
      step(2);
      check("rsp_hold_valid", rsp_valid, 0);
      check("rsp_hold_data", rsp_rdata, 16'hA55A);

      // 3. byte enables
      req(1'b1, 3'd5, 16'h1234, 2'b11, 16'h0);
      req(1'b1, 3'd5, 16'hFFEE, 2'b01, 16'h0);
      req(1'b1, 3'd5, 16'h9900, 2'b00, 16'h0);
      req(1'b0, 3'd5, 16'h0, 2'b00, 16'h12EE);
      req_off();
      step(2);

      // 4. streaming
      for (int k = 0; k < 8; k++) req(1'b1, 3'(k), 16'h0100 + 16'(k), 2'b11, 16'h0);
      for (int k = 0; k < 8; k++) req(1'b0, 3'(k), 16'h0, 2'b00, 16'h0100 + 16'(k));
      req_off();
      step(2);

      // 5. clear vs request
      req(1'b1, 3'd3, 16'hA55A, 2'b11, 16'h0);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd3; clr_start = 1'b1;
      q.push_back('{16'hA55A, cyc + 1});
      @(posedge clk); #1;
      clr_start = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 20) begin
         check("sweep_ready_low", req_ready, 0);
         clr_start = (n == 3);
         @(posedge clk); #1;
         n++;
      end
      clr_start = 1'b0;
      check("sweep2_len", n, 8);
      check("sweep2_done", clr_done, 1);
      check("sweep2_ready", req_ready, 1);
      q.push_back('{16'h0000, cyc + 1});
      @(posedge clk); #1;
      req_off();
      step(2);

      // 6. reset drops an in-flight read, then reset mid-sweep
      req(1'b1, 3'd2, 16'hBEEF, 2'b11, 16'h0);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd2;
      @(posedge clk); #1;
      req_off();
      rst = 1'b1;
      #1;
      check("rst_drop_rsp", rsp_valid, 0);
      check("rst_drop_busy", busy, 1);
      step(1);
      rst = 1'b0;
      step(4);
      rst = 1'b1;
      #1;
      check("mid_rst_busy", busy, 1);
      check("mid_rst_rsp_valid", rsp_valid, 0);
      check("mid_rst_clr_done", clr_done, 0);
      check("mid_rst_ready", req_ready, 0);
      step(1);
      rst = 1'b0;
      count_busy(n);
      check("sweep3_len", n, 8);
      check("sweep3_done", clr_done, 1);
      req(1'b0, 3'd3, 16'h0, 2'b00, 16'h0000);
      req_off();
      step(3);
      check("queue_empty", q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
